brick_map_ctrl: RTL and testbench

//   Owns the 300-brick alive map (10 rows x 30 cols) for the breakout game. Loads the

---
 rtl/brick_pkg.sv | 37 +++
 rtl/brick_pattern_rom.sv | 14 +
 rtl/brick_map_ctrl.sv | 120 ++++++++++++
 tb/tb_brick_map_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared constants, FSM encoding and level pattern helpers for the brick map.
// Level 3 reuses the level 0 layout.
package brick_pkg;

  localparam int ROWS   = 10;
  localparam int COLS   = 30;
  localparam int NBRICK = ROWS * COLS;
  localparam int CNT_W  = 9;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_PLAY = 1'b1
  } state_e;

  function automatic logic [4:0] popcount30(input logic [COLS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [COLS-1:0] pattern_row(input logic [1:0] level, input logic [3:0] row);
    logic [COLS-1:0] p;
    p = '0;
    for (int c = 0; c < COLS; c++) begin
      case (level)
        2'd1:    p[c] = (row < 4'd6) && (((int'(row) + c) % 2) == 0);
        2'd2:    p[c] = (c % 3) != 2;
        default: p[c] = (row < 4'd4);
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/brick_pattern_rom.sv
// Combinational pattern lookup: one map row for a given level plus its brick count.
module brick_pattern_rom
  import brick_pkg::*;
(
  input  logic [1:0]      level_i,
  input  logic [3:0]      row_i,
  output logic [COLS-1:0] row_bits_o,
  output logic [4:0]      row_cnt_o
);

  assign row_bits_o = pattern_row(level_i, row_i);
  assign row_cnt_o  = popcount30(row_bits_o);

endmodule

// File: rtl/brick_map_ctrl.sv
// Brick alive-map owner: per-level row-by-row load, hit clearing with a one-cycle
// acknowledge, and the remaining-brick count feeding the level controller.
module brick_map_ctrl #(
  parameter int ROWS  = 10,
  parameter int COLS  = 30,
  parameter int CNT_W = 9
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [1:0]           iLevel,
  input  logic                 iLevel_RST,
  input  logic                 iHit_valid,
  input  logic [3:0]           iHit_row,
  input  logic [4:0]           iHit_col,
  output logic [ROWS*COLS-1:0] oState_flag,
  output logic [CNT_W-1:0]     oBrick_left,
  output logic                 oHit_ack,
  output logic                 oHit_brick,
  output logic                 oLoading,
  output logic                 oCleared
);

  import brick_pkg::state_e;
  import brick_pkg::S_LOAD;
  import brick_pkg::S_PLAY;

  state_e               state_q, state_d;
  logic [3:0]           row_q, row_d;
  logic [ROWS*COLS-1:0] map_q, map_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 hbrick_q, hbrick_d;
  logic                 cleared_q, cleared_d;
  logic [1:0]           prev_lvl_q;
  logic                 prev_rst_q;

  logic [COLS-1:0]      rom_bits;
  logic [4:0]           rom_cnt;
  logic                 trig;
  logic                 hit_in_range;
  logic [8:0]           hit_idx;

  brick_pattern_rom u_rom (
    .level_i    (iLevel),
    .row_i      (row_q),
    .row_bits_o (rom_bits),
    .row_cnt_o  (rom_cnt)
  );

  // A level change or a falling edge on the restart strobe restarts the load from row 0.
  assign trig         = (iLevel != prev_lvl_q) || (prev_rst_q && !iLevel_RST);
  assign hit_in_range = (iHit_row < 4'(ROWS)) && (iHit_col < 5'(COLS));
  assign hit_idx      = 9'(iHit_row) * 9'(COLS) + 9'(iHit_col);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    map_d     = map_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    hbrick_d  = 1'b0;
    cleared_d = 1'b0;
    if (trig) begin
      state_d = S_LOAD;
      row_d   = '0;
    end else if (state_q == S_LOAD) begin
      // Rows are overwritten in place so the map is never blanked during a reload.
      map_d[int'(row_q)*COLS +: COLS] = rom_bits;
      cnt_d = (row_q == 4'd0) ? CNT_W'(rom_cnt) : cnt_q + CNT_W'(rom_cnt);
      if (row_q == 4'(ROWS-1)) begin
        state_d = S_PLAY;
        row_d   = '0;
      end else begin
        row_d = row_q + 4'd1;
      end
    end else begin
      cleared_d = (cnt_q == '0);
      if (iHit_valid && !ack_q) begin
        ack_d = 1'b1;
        if (hit_in_range && map_q[hit_idx]) begin
          hbrick_d       = 1'b1;
          map_d[hit_idx] = 1'b0;
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q    <= S_LOAD;
      row_q      <= '0;
      map_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      hbrick_q   <= 1'b0;
      cleared_q  <= 1'b0;
      prev_lvl_q <= iLevel;
      prev_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      map_q      <= map_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      hbrick_q   <= hbrick_d;
      cleared_q  <= cleared_d;
      prev_lvl_q <= iLevel;
      prev_rst_q <= iLevel_RST;
    end
  end

  assign oState_flag = map_q;
  assign oBrick_left = cnt_q;
  assign oHit_ack    = ack_q;
  assign oHit_brick  = hbrick_q;
  assign oLoading    = (state_q == S_LOAD);
  assign oCleared    = cleared_q;

endmodule

// File: tb/tb_brick_map_ctrl.sv
// Scoreboard bench for brick_map_ctrl: directed hits push expected results, a monitor
// checks them on every acknowledge; load timing and reset values are checked inline.
module tb_brick_map_ctrl;

  logic         iCLK = 1'b0;
  logic         iRST;
  logic [1:0]   iLevel;
  logic         iLevel_RST;
  logic         iHit_valid;
  logic [3:0]   iHit_row;
  logic [4:0]   iHit_col;
  logic [299:0] oState_flag;
  logic [8:0]   oBrick_left;
  logic         oHit_ack;
  logic         oHit_brick;
  logic         oLoading;
  logic         oCleared;

  always #5 iCLK = ~iCLK;

  brick_map_ctrl dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iLevel      (iLevel),
    .iLevel_RST  (iLevel_RST),
    .iHit_valid  (iHit_valid),
    .iHit_row    (iHit_row),
    .iHit_col    (iHit_col),
    .oState_flag (oState_flag),
    .oBrick_left (oBrick_left),
    .oHit_ack    (oHit_ack),
    .oHit_brick  (oHit_brick),
    .oLoading    (oLoading),
    .oCleared    (oCleared)
  );

  typedef struct {
    bit           brick;
    int           cnt;
    logic [299:0] map;
  } sb_t;

  sb_t          sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [299:0] exp_map;

  task automatic check(input string nm, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [299:0] lvl_map(input int lv);
    logic [299:0] m;
    m = '0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 30; c++)
        case (lv)
          1:       m[r*30+c] = (r < 6) && ((r + c) % 2 == 0);
          2:       m[r*30+c] = (c % 3) != 2;
          default: m[r*30+c] = (r < 4);
        endcase
    return m;
  endfunction

  // Monitor: every acknowledge consumes one expected entry.
  always @(negedge iCLK) begin
    if (iRST === 1'b1 && oHit_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("hit_brick", 300'(oHit_brick), 300'(e.brick));
        check("hit_count", 300'(oBrick_left), 300'(e.cnt));
        check("hit_map", oState_flag, e.map);
      end
    end
  end

  // Issue a hit and hold it until acknowledged; called just after a falling edge.
  task automatic do_hit(input int r, input int c, input bit exp_brick, input int exp_cnt,
                        output int waited);
    sb_t e;
    if (exp_brick) exp_map[r*30+c] = 1'b0;
    e.brick = exp_brick;
    e.cnt   = exp_cnt;
    e.map   = exp_map;
    sb.push_back(e);
    iHit_row   = 4'(r);
    iHit_col   = 5'(c);
    iHit_valid = 1'b1;
    waited     = 0;
    do begin
      @(negedge iCLK);
      waited++;
    end while (oHit_ack !== 1'b1 && waited < 40);
    if (oHit_ack !== 1'b1) check("hit_ack_timeout", 300'(oHit_ack), 300'(1));
    iHit_valid = 1'b0;
  endtask

  task automatic wait_load(output int n);
    n = 0;
    while (oLoading === 1'b1 && n < 50) begin
      n++;
      @(negedge iCLK);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    int cnt;
    iRST = 1'b0; iLevel = 2'd0; iLevel_RST = 1'b1;
    iHit_valid = 1'b0; iHit_row = '0; iHit_col = '0;
    repeat (3) @(negedge iCLK);
    check("rst_map", oState_flag, '0);
    check("rst_count", 300'(oBrick_left), 300'(0));
    check("rst_ack", 300'(oHit_ack), 300'(0));
    check("rst_brick", 300'(oHit_brick), 300'(0));
    check("rst_cleared", 300'(oCleared), 300'(0));
    check("rst_loading", 300'(oLoading), 300'(1));

    // Level 0 load after reset release
    iRST = 1'b1;
    wait_load(w);
    check("l0_load_cycles", 300'(w), 300'(10));
    check("l0_count", 300'(oBrick_left), 300'(120));
    check("l0_map", oState_flag, {180'b0, {120{1'b1}}});
    check("l0_cleared", 300'(oCleared), 300'(0));
    exp_map = lvl_map(0);

    do_hit(0, 0, 1'b1, 119, w);
    do_hit(0, 0, 1'b0, 119, w);
    do_hit(12, 3, 1'b0, 119, w);
    do_hit(2, 31, 1'b0, 119, w);

    // Hit pending across a restart-strobe reload: ack only after the load finishes
    @(negedge iCLK);
    exp_map = lvl_map(0);
    iLevel_RST = 1'b0;
    fork
      do_hit(1, 1, 1'b1, 119, w);
      begin
        @(negedge iCLK);
        iLevel_RST = 1'b1;
      end
    join
    check("load_hit_wait", 300'(w), 300'(12));

    // Clear every remaining level 0 brick
    cnt = 119;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 30; c++) begin
        if (!(r == 1 && c == 1)) begin
          cnt--;
          do_hit(r, c, 1'b1, cnt, w);
        end
      end
    check("cleared_same_cycle", 300'(oCleared), 300'(0));
    @(negedge iCLK);
    check("cleared_next_cycle", 300'(oCleared), 300'(1));
    check("empty_map", oState_flag, '0);
    do_hit(0, 0, 1'b0, 0, w);

    // Level 0 -> 1 reload
    iLevel = 2'd1;
    @(negedge iCLK);
    check("l1_loading", 300'(oLoading), 300'(1));
    check("l1_cleared_low", 300'(oCleared), 300'(0));
    wait_load(w);
    check("l1_load_cycles", 300'(w), 300'(10));
    check("l1_count", 300'(oBrick_left), 300'(90));
    check("l1_map", oState_flag, lvl_map(1));
    check("l1_cleared", 300'(oCleared), 300'(0));

    // Restart strobe, then level change while row 4 is loading
    iLevel_RST = 1'b0;
    @(negedge iCLK);
    iLevel_RST = 1'b1;
    repeat (4) @(negedge iCLK);
    check("midload_loading", 300'(oLoading), 300'(1));
    check("midload_map", oState_flag, lvl_map(1));
    iLevel = 2'd2;
    @(negedge iCLK);
    wait_load(w);
    check("l2_load_cycles", 300'(w), 300'(10));
    check("l2_count", 300'(oBrick_left), 300'(200));
    check("l2_map", oState_flag, lvl_map(2));

    // Reset in the middle of a load
    iLevel_RST = 1'b0;
    @(negedge iCLK);
    iLevel_RST = 1'b1;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    check("mrst_map", oState_flag, '0);
    check("mrst_count", 300'(oBrick_left), 300'(0));
    check("mrst_ack", 300'(oHit_ack), 300'(0));
    check("mrst_brick", 300'(oHit_brick), 300'(0));
    check("mrst_cleared", 300'(oCleared), 300'(0));
    check("mrst_loading", 300'(oLoading), 300'(1));
    iRST = 1'b1;
    wait_load(w);
    check("post_rst_load_cycles", 300'(w), 300'(10));
    check("post_rst_count", 300'(oBrick_left), 300'(200));
    check("sb_empty", 300'(sb.size()), 300'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
